cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode CPU datapath.
- Fetches 8-bit instructions from instruction memory over a req/valid handshake and holds the program counter.
- Registers ALU flags and drives the ALU/register-file controls: op, imm_sel, reg_en, jmp_sel.
- Replaces purely combinational decode with a timed sequence, so flags used by a branch come from the previous ALU instruction.

---
 rtl/cpu_sequencer_pkg.sv | 28 ++
 rtl/cpu_sequencer_if.sv | 13 +
 rtl/cpu_branch_eval.sv | 21 ++
 rtl/cpu_sequencer.sv | 131 +++++++++++++
 tb/tb_cpu_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared opcodes, flag bit indices and FSM state encodings for the CPU sequencer.
package cpu_sequencer_pkg;

  localparam logic [3:0] OPC_JMP = 4'b1000;
  localparam logic [3:0] OPC_JZ  = 4'b1001;
  localparam logic [3:0] OPC_JC  = 4'b1010;
  localparam logic [3:0] OPC_JS  = 4'b1011;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_SF = 1;
  localparam int FLAG_CF = 2;

  typedef logic [2:0] flags_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_HALT   = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  function automatic logic is_alu(input logic [3:0] opc);
    return ~opc[3];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch bus: req/addr from the sequencer, valid/data back from memory.
interface cpu_sequencer_if #(
  parameter int PC_W  = 4,
  parameter int IMM_W = 4
);
  logic              req;
  logic [PC_W-1:0]   addr;
  logic              valid;
  logic [IMM_W+3:0]  data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/cpu_branch_eval.sv
// Combinational branch resolution from opcode and latched ALU flags.
module cpu_branch_eval
  import cpu_sequencer_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  flags_t     flags_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OPC_JMP: taken_o = 1'b1;
      OPC_JZ:  taken_o = flags_i[FLAG_ZF];
      OPC_JC:  taken_o = flags_i[FLAG_CF];
      OPC_JS:  taken_o = flags_i[FLAG_SF];
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: holds pc, ir and ALU flags, drives datapath controls.
// Optional single-step WAIT state enabled by CPU_SEQ_STEP_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int IMM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.master  imem,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic [1:0]       op,
  output logic             imm_sel,
  output logic [IMM_W-1:0] imm,
  output logic             reg_en,
  output logic             jmp_sel,
  output logic [PC_W-1:0]  pc,
  output logic             halted
`ifdef CPU_SEQ_STEP_EN
  ,
  input  logic             step
`endif
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [IMM_W+3:0]   ir_q, ir_d;
  flags_t             flags_q, flags_d;

  logic [3:0]         opcode;
  logic               taken;
  logic [PC_W-1:0]    target;

  assign opcode = ir_q[IMM_W+3:IMM_W];
  assign imm    = ir_q[IMM_W-1:0];
  assign pc     = pc_q;

  // Jump target is the immediate zero-extended or truncated to the pc width.
  generate
    if (PC_W >= IMM_W) begin : g_tgt_ext
      assign target = PC_W'(ir_q[IMM_W-1:0]);
    end else begin : g_tgt_trunc
      assign target = ir_q[PC_W-1:0];
    end
  endgenerate

  cpu_branch_eval u_branch_eval (
    .opcode_i (opcode),
    .flags_i  (flags_q),
    .taken_o  (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem.valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OPC_HLT) state_d = S_HALT;
`ifdef CPU_SEQ_STEP_EN
        else                   state_d = S_WAIT;
`else
        else                   state_d = S_FETCH;
`endif
      end
`ifdef CPU_SEQ_STEP_EN
      S_WAIT:   if (step) state_d = S_FETCH;
`else
      S_WAIT:   state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Flags are latched at the end of an ALU EXEC so a following branch sees them.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    if (state_q == S_FETCH && imem.valid) begin
      ir_d = imem.data;
    end
    if (state_q == S_EXEC) begin
      if (is_alu(opcode)) begin
        flags_d[FLAG_CF] = alu_cf;
        flags_d[FLAG_SF] = alu_sf;
        flags_d[FLAG_ZF] = alu_zf;
      end
      if (opcode != OPC_HLT) begin
        pc_d = taken ? target : pc_q + PC_W'(1);
      end
    end
  end

  always_comb begin
    imem.req  = (state_q == S_FETCH);
    imem.addr = pc_q;
    op        = 2'b00;
    imm_sel   = 1'b0;
    reg_en    = 1'b0;
    jmp_sel   = 1'b0;
    halted    = (state_q == S_HALT);
    if ((state_q == S_DECODE || state_q == S_EXEC) && is_alu(opcode)) begin
      op      = opcode[2:1];
      imm_sel = opcode[0];
    end
    if (state_q == S_EXEC) begin
      reg_en  = is_alu(opcode);
      jmp_sel = taken;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: instructions fed through a stalling memory model.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_cf = 1'b0, alu_sf = 1'b0, alu_zf = 1'b0;
  logic [1:0] op;
  logic imm_sel, reg_en, jmp_sel, halted;
  logic [3:0] imm, pc;
`ifdef CPU_SEQ_STEP_EN
  logic step = 1'b0;
`endif

  cpu_sequencer_if #(.PC_W(4), .IMM_W(4)) imem_if ();

  cpu_sequencer #(.PC_W(4), .IMM_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .imem    (imem_if),
    .alu_cf  (alu_cf),
    .alu_sf  (alu_sf),
    .alu_zf  (alu_zf),
    .op      (op),
    .imm_sel (imm_sel),
    .imm     (imm),
    .reg_en  (reg_en),
    .jmp_sel (jmp_sel),
    .pc      (pc),
    .halted  (halted)
`ifdef CPU_SEQ_STEP_EN
    ,
    .step    (step)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       alu;
    logic       reg_en;
    logic       jmp_sel;
    logic [1:0] op;
    logic       imm_sel;
    logic [3:0] imm;
    logic [3:0] pc_next;
    logic       halt;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_pc = 4'h0;
  logic       m_cf = 1'b0, m_sf = 1'b0, m_zf = 1'b0;

  // Runs one instruction: memory answers after 'stall' cycles; flags are what the ALU shows in EXEC.
  task automatic run_instr(input logic [7:0] instr, input int stall,
                           input logic cf, input logic sf, input logic zf);
    int   wait_cnt;
    exp_t e;
    exp_t got;
    logic [3:0] opc;
    logic [3:0] addr0;
    logic tk;
    opc = instr[7:4];
    wait_cnt = 0;
    while (imem_if.req !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (imem_if.req !== 1'b1) begin
      check_val("req_timeout", {31'd0, imem_if.req}, 32'd1);
      return;
    end
    check_val("fetch_addr", {28'd0, imem_if.addr}, {28'd0, m_pc});
    addr0 = imem_if.addr;
    for (int i = 0; i < stall; i++) begin
      imem_if.valid = 1'b0;
      @(negedge clk);
      check_val("stall_addr", {28'd0, imem_if.addr}, {28'd0, addr0});
      check_val("stall_req", {31'd0, imem_if.req}, 32'd1);
    end
    imem_if.valid = 1'b1;
    imem_if.data  = instr;
    tk = (opc == 4'h8) || (opc == 4'h9 && m_zf) || (opc == 4'hA && m_cf) || (opc == 4'hB && m_sf);
    e.alu     = ~opc[3];
    e.reg_en  = ~opc[3];
    e.jmp_sel = tk;
    e.op      = opc[3] ? 2'b00 : opc[2:1];
    e.imm_sel = opc[3] ? 1'b0 : opc[0];
    e.imm     = instr[3:0];
    e.halt    = (opc == 4'hF);
    e.pc_next = e.halt ? m_pc : (tk ? instr[3:0] : m_pc + 4'h1);
    exp_q.push_back(e);
    @(negedge clk);
    imem_if.valid = 1'b0;
    imem_if.data  = 8'h00;
    check_val("dec_reg_en", {31'd0, reg_en}, 32'd0);
    check_val("dec_jmp_sel", {31'd0, jmp_sel}, 32'd0);
    if (exp_q[0].alu) begin
      check_val("dec_op", {30'd0, op}, {30'd0, exp_q[0].op});
      check_val("dec_imm_sel", {31'd0, imm_sel}, {31'd0, exp_q[0].imm_sel});
    end
    alu_cf = cf;
    alu_sf = sf;
    alu_zf = zf;
    @(negedge clk);
    got = exp_q.pop_front();
    check_val("exe_reg_en", {31'd0, reg_en}, {31'd0, got.reg_en});
    check_val("exe_jmp_sel", {31'd0, jmp_sel}, {31'd0, got.jmp_sel});
    check_val("exe_imm", {28'd0, imm}, {28'd0, got.imm});
    if (got.alu) begin
      check_val("exe_op", {30'd0, op}, {30'd0, got.op});
      check_val("exe_imm_sel", {31'd0, imm_sel}, {31'd0, got.imm_sel});
      m_cf = cf;
      m_sf = sf;
      m_zf = zf;
    end
    m_pc = got.pc_next;
    @(negedge clk);
    alu_cf = 1'b0;
    alu_sf = 1'b0;
    alu_zf = 1'b0;
    check_val("pc_after", {28'd0, pc}, {28'd0, m_pc});
    check_val("halted", {31'd0, halted}, {31'd0, got.halt});
    check_val("reg_en_pulse", {31'd0, reg_en}, 32'd0);
    check_val("jmp_sel_pulse", {31'd0, jmp_sel}, 32'd0);
    if (got.halt) begin
      check_val("halt_req", {31'd0, imem_if.req}, 32'd0);
    end else begin
`ifdef CPU_SEQ_STEP_EN
      check_val("wait_req", {31'd0, imem_if.req}, 32'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
`else
      check_val("next_req", {31'd0, imem_if.req}, 32'd1);
`endif
    end
  endtask

  typedef struct {
    logic [7:0] instr;
    int         stall;
    logic       cf, sf, zf;
  } stim_t;

  stim_t prog[12] = '{
    '{8'h15, 0, 1'b0, 1'b0, 1'b0},
    '{8'h27, 3, 1'b0, 1'b0, 1'b1},
    '{8'h9A, 0, 1'b0, 1'b0, 1'b0},
    '{8'h30, 1, 1'b1, 1'b0, 1'b0},
    '{8'h9A, 0, 1'b0, 1'b0, 1'b1},
    '{8'hA3, 2, 1'b0, 1'b0, 1'b0},
    '{8'hB5, 0, 1'b0, 1'b1, 1'b0},
    '{8'h8F, 0, 1'b0, 1'b0, 1'b0},
    '{8'hC0, 0, 1'b0, 1'b0, 1'b0},
    '{8'h4E, 0, 1'b0, 1'b1, 1'b0},
    '{8'hB2, 0, 1'b1, 1'b0, 1'b1},
    '{8'hF0, 0, 1'b0, 1'b0, 1'b0}
  };

  initial begin
    int bad_halt;
    int fetches;
    imem_if.valid = 1'b0;
    imem_if.data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_pc", {28'd0, pc}, 32'd0);
    check_val("rst_op", {30'd0, op}, 32'd0);
    check_val("rst_reg_en", {31'd0, reg_en}, 32'd0);
    check_val("rst_jmp_sel", {31'd0, jmp_sel}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_imm", {28'd0, imm}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("first_req", {31'd0, imem_if.req}, 32'd1);

    foreach (prog[i]) begin
      run_instr(prog[i].instr, prog[i].stall, prog[i].cf, prog[i].sf, prog[i].zf);
    end

    // Memory keeps offering data while halted; nothing must be fetched.
    imem_if.valid = 1'b1;
    imem_if.data  = 8'h15;
    bad_halt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || imem_if.req !== 1'b0 || reg_en !== 1'b0) bad_halt++;
    end
    check_val("halt_hold", bad_halt, 32'd0);
    check_val("halt_pc", {28'd0, pc}, {28'd0, m_pc});
    imem_if.valid = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst2_pc", {28'd0, pc}, 32'd0);
    check_val("rst2_halted", {31'd0, halted}, 32'd0);
    check_val("rst2_req", {31'd0, imem_if.req}, 32'd1);
    m_pc = 4'h0;
    m_cf = 1'b0;
    m_sf = 1'b0;
    m_zf = 1'b0;
    // Flags are cleared by reset, so JZ after reset falls through.
    run_instr(8'h97, 0, 1'b0, 1'b0, 1'b1);

`ifdef CPU_SEQ_STEP_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_if.valid = 1'b1;
    imem_if.data  = 8'hC0;
    fetches = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_if.req === 1'b1) fetches++;
      @(negedge clk);
    end
    check_val("step_first_fetches", fetches, 32'd1);
    check_val("step_first_pc", {28'd0, pc}, 32'd1);
    fetches = 0;
    for (int i = 0; i < 14; i++) begin
      step = (i < 4);
      if (imem_if.req === 1'b1) fetches++;
      @(negedge clk);
    end
    step = 1'b0;
    check_val("step_wide_fetches", fetches, 32'd1);
    check_val("step_wide_pc", {28'd0, pc}, 32'd2);
    imem_if.valid = 1'b0;
`else
    fetches = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
